// File: rtl/dmem_arbiter.sv
// Purpose: arbitrates the single-port data memory between the pipeline (p0) and the loader (p1), with a starvation bound for p1.
// Latency: grant and memory drive are combinational; read data returns one cycle after the winning read.
// Backpressure: a losing p0 sees p0_stall; p1 holds its request until p1_gnt. Optional p1 lock: DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_stall,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_LOCK_EN
  ,
  input  logic              p1_lock
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       locked;
  logic       p0_wins_raw;
  logic       p1_wins_raw;
  logic       p0_wins;
  logic       p1_wins;
  logic       rd_vld;
  logic       rd_port;

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t state;
  lock_state_t state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= UNLOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCKED: if (p1_wins && p1_lock) state_nxt = LOCKED;
      LOCKED:   if (!p1_lock) state_nxt = UNLOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  assign locked = (state == LOCKED);
`else
  assign locked = 1'b0;
`endif

  // A held lock also shuts p0 out when p1 is idle, so p0 stalls for the whole lock.
  always_comb begin
    p1_wins_raw = p1_req & (~p0_req | locked | (starve_cnt >= STARVE_LIM));
    p0_wins_raw = p0_req & ~p1_wins_raw & ~locked;
  end

  assign p0_wins = reset & p0_wins_raw;
  assign p1_wins = reset & p1_wins_raw;

  // Address/data keep following the winner during reset; only the strobes are gated.
  always_comb begin
    mem_en    = p0_wins | p1_wins;
    mem_we    = (p0_wins & p0_we) | (p1_wins & p1_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (p1_wins_raw) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end else if (p0_wins_raw) begin
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end
  end

  assign p0_stall = p0_req & ~p0_wins;
  assign p1_gnt   = p1_wins;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (p1_req && !p1_wins) begin
      if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld  <= 1'b0;
      rd_port <= 1'b0;
    end else begin
      rd_vld  <= mem_en & ~mem_we;
      rd_port <= p1_wins;
    end
  end

  assign p0_rvalid = rd_vld & ~rd_port;
  assign p1_rvalid = rd_vld & rd_port;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a cycle-level model of who gets the memory and what each read must return.
module tb_dmem_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr, mem_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          p0_stall, p0_rvalid, p1_gnt, p1_rvalid, mem_en, mem_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_stall(p0_stall), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory attached to the arbiter
  logic [DW-1:0] mem    [0:255];
  logic [DW-1:0] shadow [0:255];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference state: p1's losing streak, the read owed next cycle, and memory contents.
  int            lost     = 0;
  bit            pend_vld = 0;
  bit            pend_p1  = 0;
  logic [DW-1:0] pend_dat = '0;
  int            last_win = -1;

  task automatic step(input bit rst,
                      input bit r0, input bit w0, input logic [15:0] a0, input logic [15:0] d0,
                      input bit r1, input bit w1, input logic [15:0] a1, input logic [15:0] d1);
    int       win;
    bit       we;
    bit       rv0, rv1;
    logic [15:0] ea, ed;
    @(negedge clk);
    reset = !rst;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #1;
    rv0 = pend_vld && !pend_p1 && !rst;
    rv1 = pend_vld &&  pend_p1 && !rst;
    chk("p0_rvalid", 32'(p0_rvalid), 32'(rv0));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(rv1));
    chk("p0_rdata", 32'(p0_rdata), rv0 ? 32'(pend_dat) : 32'd0);
    chk("p1_rdata", 32'(p1_rdata), rv1 ? 32'(pend_dat) : 32'd0);
    chk("starve_cnt", 32'(dut.starve_cnt), rst ? 32'd0 : 32'(lost));

    if (rst)            win = -1;
    else if (r0 && r1)  win = (lost >= SMAX) ? 1 : 0;
    else if (r0)        win = 0;
    else if (r1)        win = 1;
    else                win = -1;
    last_win = win;
    we = (win == 0) ? w0 : (win == 1) ? w1 : 1'b0;
    ea = (win == 0) ? a0 : (win == 1) ? a1 : 16'h0;
    ed = (win == 0) ? d0 : (win == 1) ? d1 : 16'h0;

    chk("mem_en", 32'(mem_en), 32'(win >= 0));
    chk("mem_we", 32'(mem_we), 32'(we));
    chk("p1_gnt", 32'(p1_gnt), 32'(win == 1));
    chk("p0_stall", 32'(p0_stall), 32'(r0 && win != 0));
    if (win >= 0) begin
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      if (we) chk("mem_wdata", 32'(mem_wdata), 32'(ed));
    end else if (!rst) begin
      chk("mem_addr_idle", 32'(mem_addr), 32'd0);
      chk("mem_wdata_idle", 32'(mem_wdata), 32'd0);
    end

    if (rst) begin
      lost     = 0;
      pend_vld = 0;
    end else begin
      lost = (r1 && win != 1) ? ((lost < 15) ? lost + 1 : 15) : 0;
      pend_vld = (win >= 0) && !we;
      pend_p1  = (win == 1);
      if (pend_vld) pend_dat = shadow[ea[7:0]];
      if (win >= 0 && we) shadow[ea[7:0]] = ed;
    end
  endtask

  task automatic idle(input bit rst);
    step(rst, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [15:0] v;
    reset = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      mem[i] = v;
      shadow[i] = v;
    end
    mem[8'h10] = 16'hBEEF;
    shadow[8'h10] = 16'hBEEF;

    idle(1);
    idle(1);
    chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    idle(0);

    // p0 read of 0x0010 returning 0xBEEF
    step(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("t1_en", 32'(mem_en), 32'd1);
    chk("t1_we", 32'(mem_we), 32'd0);
    idle(0);
    chk("t1_rdata", 32'(p0_rdata), 32'hBEEF);

    // p1 write then p0 read-back
    step(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0020, 16'h1234);
    chk("t2_gnt", 32'(p1_gnt), 32'd1);
    step(0, 1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0);
    idle(0);
    chk("t2_rdata", 32'(p0_rdata), 32'h1234);

    // Both held: p1 forced through on the fifth cycle
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 16'(i), 16'h0, 1, 0, 16'(i + 64), 16'h0);
      chk("t3_gnt", 32'(p1_gnt), 32'(i == 4));
      chk("t3_stall", 32'(p0_stall), 32'(i == 4));
    end
    idle(0);

    // Reset before the read returns: no rvalid afterwards
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0030, 16'h0);
    step(1, 1, 0, 16'h0001, 16'h0, 1, 0, 16'h0031, 16'h0);
    idle(0);
    chk("t4_p1_rvalid", 32'(p1_rvalid), 32'd0);
    chk("t4_starve", 32'(dut.starve_cnt), 32'd0);

    // Alternating single-port reads
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(0, 1, 0, 16'(i * 3), 16'h0, 0, 0, 16'h0, 16'h0);
      else            step(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'(i * 5), 16'h0);
    end
    idle(0);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom_range(0, 255)), 16'($urandom),
           $urandom_range(0, 1) != 0, 1'($urandom), 16'($urandom_range(0, 255)), 16'($urandom));
    end
    idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters.
  - Port 0: pipeline MEM stage (priority requester).
  - Port 1: loader/debug master.
- Drives the memory's en/we/addr/wdata and routes 1-cycle-latency read data back to the winning port with a valid strobe.
- Stalls the pipeline when it loses arbitration.
- Bounded-starvation counter guarantees port 1 forward progress.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- STARVE_MAX, 4, consecutive lost cycles after which port 1 is forced to win (legal 1..15).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset asserted).
- p0_req  input  1  pipeline memory access request (mem_en_ex).
- p0_we  input  1  pipeline write (1) / read (0).
- p0_addr  input  ADDR_W  pipeline address (ALU result).
- p0_wdata  input  DATA_W  pipeline store data.
- p0_stall  output  1  pipeline must hold MEM stage this cycle.
- p0_rvalid  output  1  p0_rdata valid.
- p0_rdata  output  DATA_W  pipeline read data.
- p1_req  input  1  loader request; held until p1_gnt.
- p1_we  input  1  loader write/read.
- p1_addr  input  ADDR_W  loader address.
- p1_wdata  input  DATA_W  loader write data.
- p1_gnt  output  1  loader request accepted this cycle.
- p1_rvalid  output  1  p1_rdata valid.
- p1_rdata  output  DATA_W  loader read data.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid one cycle after a read is enabled.

Behaviour:
- Grant is combinational each cycle.
  - mem_en/we/addr/wdata are muxed from the winner and sampled by memory at the next rising edge.
  - No winner: mem_en=0, mem_we=0, addr and wdata are 0.
- Arbitration, with starve_cnt (4-bit register):
  - Only p0_req: p0 wins.
  - Only p1_req: p1 wins.
  - Both requesting:
    - p1 wins if starve_cnt >= STARVE_MAX; p0_stall=1.
    - Otherwise p0 wins.
- starve_cnt update:
  - Increments when p1_req=1 and p1 loses; saturates at 15.
  - Clears when p1 wins or p1_req=0.
- p0_stall = p0_req & ~p0_wins.
- p1_gnt = p1_wins.
- Read return:
  - A winning read (we=0) sets a registered tag {valid, port}.
  - Next cycle, that port's rvalid=1 and its rdata=mem_rdata.
  - The other port's rdata reads 0.
  - Back-to-back reads produce back-to-back rvalids.
- Writes produce no rvalid; write completes at the sampling edge.
- Reset (reset=0, async):
  - starve_cnt=0 and the read tag is cleared.
  - p0_rvalid=0, p1_rvalid=0, and the lock is released.
  - An in-flight read is dropped, with no rvalid after reset release.
  - Combinational outputs follow inputs, but during reset mem_en and mem_we are forced to 0, p1_gnt=0, and p0_stall=p0_req.
- Same-address write by one port and read by the other in the same cycle: impossible, since only one port is granted per cycle.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- When defined: extra input p1_lock (1 bit).
  - FSM states: UNLOCKED and LOCKED.
  - UNLOCKED -> LOCKED when p1 is granted with p1_lock=1.
  - LOCKED -> UNLOCKED when p1_lock=0 at a rising edge.
  - While LOCKED, p1 wins unconditionally whenever p1_req=1, and p0_stall = p0_req.
  - Reset forces UNLOCKED.
- When undefined: no p1_lock port; behaviour is exactly as in Behaviour above.

Test Plan:
- p0 read addr 0x0010, memory model returns 0xBEEF -> mem_en=1, mem_we=0 that cycle; next cycle p0_rvalid=1, p0_rdata=0xBEEF; p0_stall=0 throughout.
- p1 write addr 0x0020 data 0x1234 alone, then p0 read 0x0020 -> p1_gnt=1, mem_we=1; p0 read returns 0x1234 one cycle later; p1_rvalid never asserts.
- p0_req and p1_req both held high, STARVE_MAX=4 -> p0 wins cycles 1-4, p1_gnt=1 and p0_stall=1 in cycle 5, starve_cnt=0 in cycle 6, p0 wins again.
- p1 read issued, reset pulled low before the return edge -> p1_rvalid stays 0 after reset release; starve_cnt=0.
- Alternating p0 and p1 reads on successive cycles -> p0_rvalid and p1_rvalid alternate, each one cycle after its grant, with correct data routing.
- (DMEM_ARB_LOCK_EN) p1 granted with p1_lock=1 for 3 writes while p0_req=1 -> p0_stall=1 for all 3 cycles; lock drops, p0 granted next cycle.
